// File: rtl/switch_debouncer.sv
// Per-bit synchroniser + stability-counter debouncer with registered rise/fall pulses.
// Optional sticky change flags with clear strobes when SW_EVENT_LATCH_EN is defined.

module switch_debouncer_bit #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_db,
    output logic sw_rise,
    output logic sw_fall
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {STABLE, COUNTING} state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;

    assign sync = sync_ff[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= STABLE;
            cnt     <= '0;
            sync_ff <= '0;
            sw_db   <= 1'b0;
            sw_rise <= 1'b0;
            sw_fall <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], sw_raw};
            sw_rise <= 1'b0;
            sw_fall <= 1'b0;
            case (state)
                STABLE: begin
                    if (sync != sw_db) begin
                        cnt   <= CW'(1);
                        state <= COUNTING;
                    end else begin
                        cnt <= '0;
                    end
                end
                COUNTING: begin
                    if (sync == sw_db) begin
                        // bounce: abandon the count without touching the output
                        cnt   <= '0;
                        state <= STABLE;
                    end else if (cnt == TERM) begin
                        sw_db   <= sync;
                        sw_rise <= sync;
                        sw_fall <= ~sync;
                        cnt     <= '0;
                        state   <= STABLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= STABLE;
                end
            endcase
        end
    end
endmodule

module switch_debouncer #(
    parameter int N_SW            = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_db,
    output logic [N_SW-1:0] sw_rise,
`ifdef SW_EVENT_LATCH_EN
    output logic [N_SW-1:0] sw_fall,
    input  logic [N_SW-1:0] clr_event,
    output logic [N_SW-1:0] sw_event
`else
    output logic [N_SW-1:0] sw_fall
`endif
);
    for (genvar i = 0; i < N_SW; i++) begin : g_bit
        switch_debouncer_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk    (clk),
            .reset  (reset),
            .sw_raw (sw_raw[i]),
            .sw_db  (sw_db[i]),
            .sw_rise(sw_rise[i]),
            .sw_fall(sw_fall[i])
        );
    end

`ifdef SW_EVENT_LATCH_EN
    // set has priority over a coincident clear so no edge is ever lost
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sw_event <= '0;
        else       sw_event <= (sw_event & ~clr_event) | sw_rise | sw_fall;
    end
`endif
endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer (N_SW=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).

module tb_switch_debouncer;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sw_raw;
    logic [3:0] sw_db, sw_rise, sw_fall;
    logic [3:0] clr_event;
`ifdef SW_EVENT_LATCH_EN
    logic [3:0] sw_event;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    switch_debouncer #(
        .N_SW           (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_raw   (sw_raw),
        .sw_db    (sw_db),
        .sw_rise  (sw_rise),
`ifdef SW_EVENT_LATCH_EN
        .sw_fall  (sw_fall),
        .clr_event(clr_event),
        .sw_event (sw_event)
`else
        .sw_fall  (sw_fall)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1: reset with all switches high, then 6-edge latency
        reset = 1'b1; sw_raw = 4'hF; clr_event = 4'h0;
        repeat (3) tick();
        chk("rst_db", sw_db, 4'h0);
        chk("rst_rise", sw_rise, 4'h0);
        chk("rst_fall", sw_fall, 4'h0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t1_wait_db", sw_db, 4'h0);
        end
        tick();
        chk("t1_db", sw_db, 4'hF);
        chk("t1_rise", sw_rise, 4'hF);
        chk("t1_fall", sw_fall, 4'h0);
        tick();
        chk("t1_rise_end", sw_rise, 4'h0);
        chk("t1_db_hold", sw_db, 4'hF);

        // 2: 3-cycle glitch on bit 0 is rejected
        sw_raw = 4'h0;
        repeat (8) tick();
        chk("t2_settle", sw_db, 4'h0);
        sw_raw = 4'h1;
        repeat (3) tick();
        sw_raw = 4'h0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t2_db", sw_db, 4'h0);
            chk("t2_rise", sw_rise, 4'h0);
        end

        // 3: clean rise then fall on bit 1
        sw_raw = 4'h2;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_wait_r", sw_db, 4'h0);
        end
        tick();
        chk("t3_db_r", sw_db, 4'h2);
        chk("t3_rise", sw_rise, 4'h2);
        chk("t3_nofall", sw_fall, 4'h0);
        tick();
        chk("t3_rise_end", sw_rise, 4'h0);
        sw_raw = 4'h0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_wait_f", sw_db, 4'h2);
        end
        tick();
        chk("t3_db_f", sw_db, 4'h0);
        chk("t3_fall", sw_fall, 4'h2);
        chk("t3_norise", sw_rise, 4'h0);
        tick();
        chk("t3_fall_end", sw_fall, 4'h0);

        // 4: bits 0 and 3 together
        sw_raw = 4'h9;
        repeat (5) tick();
        chk("t4_wait", sw_db, 4'h0);
        tick();
        chk("t4_db_r", sw_db, 4'h9);
        chk("t4_rise", sw_rise, 4'h9);
        tick();
        chk("t4_rise_end", sw_rise, 4'h0);
        sw_raw = 4'h0;
        repeat (5) tick();
        chk("t4_wait_f", sw_db, 4'h9);
        tick();
        chk("t4_db_f", sw_db, 4'h0);
        chk("t4_fall", sw_fall, 4'h9);
        tick();
        chk("t4_fall_end", sw_fall, 4'h0);

        // 5: reset mid-count on bit 2 (cnt==2 after 4 edges)
        sw_raw = 4'hB;
        repeat (8) tick();
        chk("t5_pre", sw_db, 4'hB);
        sw_raw = 4'hF;
        repeat (4) tick();
        chk("t5_counting", sw_db, 4'hB);
        #2 reset = 1'b1;
        #1;
        chk("t5_async_db", sw_db, 4'h0);
        chk("t5_async_rise", sw_rise, 4'h0);
        chk("t5_async_fall", sw_fall, 4'h0);
        sw_raw = 4'h0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_post_db", sw_db, 4'h0);
            chk("t5_post_rise", sw_rise, 4'h0);
            chk("t5_post_fall", sw_fall, 4'h0);
        end

`ifdef SW_EVENT_LATCH_EN
        // 6: sticky event flags, set wins over clear
        chk("t6_ev0", sw_event, 4'h0);
        sw_raw = 4'h4;
        repeat (6) tick();
        chk("t6_rise", sw_rise, 4'h4);
        tick();
        chk("t6_ev_set", sw_event, 4'h4);
        sw_raw = 4'h0;
        repeat (6) tick();
        chk("t6_fall", sw_fall, 4'h4);
        clr_event = 4'h4;
        tick();
        chk("t6_set_wins", sw_event, 4'h4);
        clr_event = 4'h0;
        tick();
        chk("t6_hold", sw_event, 4'h4);
        clr_event = 4'h4;
        tick();
        chk("t6_clear", sw_event, 4'h0);
        clr_event = 4'h0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
